// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Shift-add multiply and restoring divide, 32 iterations, registered result.
module ex_muldiv_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        ex_stall_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q, mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] rem_q, quo_q, dvsr_q;
    logic [31:0] result_q;

    logic        accept, is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, fast, neg_d;
    logic [31:0] fast_res;

    assign accept = (state_q == S_IDLE) && start_i && !flush_i;
    assign is_div = op_i[2];
    assign a_sgn  = (op_i == 3'b001) || (op_i == 3'b010) ||
                    (op_i == 3'b100) || (op_i == 3'b110);
    assign b_sgn  = (op_i == 3'b001) || (op_i == 3'b100) ||
                    (op_i == 3'b110);
    assign a_neg  = a_sgn && a_i[31];
    assign b_neg  = b_sgn && b_i[31];
    assign a_mag  = a_neg ? -a_i : a_i;
    assign b_mag  = b_neg ? -b_i : b_i;

    assign div_zero = is_div && (b_i == 32'd0);
    assign div_ovf  = is_div && !op_i[0] &&
                      (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign fast     = div_zero || div_ovf;

    always_comb begin
        fast_res = 32'd0;
        if (div_zero)
            fast_res = op_i[1] ? a_i : 32'hFFFF_FFFF;
        else if (div_ovf)
            fast_res = op_i[1] ? 32'd0 : 32'h8000_0000;
    end

    // Remainder takes the dividend's sign; everything else the sign xor.
    assign neg_d = (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);

    logic [63:0] acc_nxt, prod;
    logic [32:0] shl, diff;
    logic [31:0] rem_nxt, quo_nxt, qv, rv, run_res;
    logic        last;

    assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign shl     = {rem_q, quo_q[31]};
    assign diff    = shl - {1'b0, dvsr_q};
    assign rem_nxt = diff[32] ? shl[31:0] : diff[31:0];
    assign quo_nxt = {quo_q[30:0], ~diff[32]};
    assign last    = (cnt_q == 6'd31);

    assign prod = neg_q ? -acc_nxt : acc_nxt;
    assign qv   = neg_q ? -quo_nxt : quo_nxt;
    assign rv   = neg_q ? -rem_nxt : rem_nxt;

    always_comb begin
        run_res = prod[63:32];
        if (op_q[2])
            run_res = op_q[1] ? rv : qv;
        else if (op_q[1:0] == 2'b00)
            run_res = prod[31:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = fast ? S_DONE : S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  if (!ex_stall_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            result_q <= 32'd0;
        end else if (accept) begin
            op_q     <= op_i;
            neg_q    <= neg_d;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            mcand_q  <= {32'd0, a_mag};
            mplier_q <= b_mag;
            rem_q    <= 32'd0;
            quo_q    <= a_mag;
            dvsr_q   <= b_mag;
            if (fast)
                result_q <= fast_res;
        end else if (state_q == S_RUN) begin
            cnt_q    <= cnt_q + 6'd1;
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            rem_q    <= rem_nxt;
            quo_q    <= quo_nxt;
            if (last && !flush_i)
                result_q <= run_res;
        end
    end

    assign busy_o   = (state_q == S_RUN);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vector table, random ops against
// an arithmetic reference model, and flush/stall/reset sequences.
module tb_ex_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        ex_stall_i, flush_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;

    ex_muldiv_unit dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .ex_stall_i (ex_stall_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        logic [63:0] p;
        p = 64'd0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int explat, input string nm);
        int  lat;
        logic bad;
        @(negedge clk_i);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        a_i = $urandom; b_i = $urandom;
        lat = 0; bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            lat++;
            if (done_o) break;
            if (busy_o !== 1'b1) bad = 1'b1;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(explat));
        chk({nm, "_res"}, result_o, exp);
        chk({nm, "_busy"}, {31'd0, bad | busy_o}, 32'd0);
        start_i = 1'b0;
    endtask

    initial begin
        int lat;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul"};
        tbl[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu"};
        tbl[2]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh"};
        tbl[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu"};
        tbl[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div"};
        tbl[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem"};
        tbl[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33, "divu"};
        tbl[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33, "remu"};
        tbl[8]  = '{3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_z"};
        tbl[9]  = '{3'd7, 32'd5, 32'd0, 32'd5, 1, "remu_z"};
        tbl[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf"};
        tbl[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf"};
        tbl[12] = '{3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_nb"};
        tbl[13] = '{3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33, "rem_nb"};
        tbl[14] = '{3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 33, "mulh_neg"};
        tbl[15] = '{3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1, "div_z"};
        tbl[16] = '{3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1, "rem_z"};

        rst_ni = 1'b0; start_i = 1'b0; op_i = 3'd0;
        a_i = 32'd0; b_i = 32'd0; ex_stall_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_res", result_o, 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 17; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp,
                  tbl[i].lat, tbl[i].nm);

        for (int i = 0; i < 48; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op(rop, ra, rb, ref_model(rop, ra, rb),
                  (rop[2] && (rb == 0 || (!rop[0] && ra == 32'h80000000
                   && rb == 32'hFFFFFFFF))) ? 1 : 33, "rand");
        end

        // Flush during a multiply at T+10
        @(negedge clk_i);
        op_i = 3'd0; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("fl_busy_before", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("fl_busy_after", {31'd0, busy_o}, 32'd0);
        chk("fl_done_after", {31'd0, done_o}, 32'd0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o || busy_o) lat++;
        end
        chk("fl_no_done", 32'(lat), 32'd0);

        // Stall in DONE with start_i held, then back-to-back accept
        @(negedge clk_i);
        op_i = 3'd5; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        @(posedge clk_i);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            lat++;
            if (done_o) break;
        end
        chk("st_lat", 32'(lat), 32'd33);
        ex_stall_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            chk("st_done_hold", {31'd0, done_o}, 32'd1);
            chk("st_res_hold", result_o, 32'd14);
            chk("st_no_busy", {31'd0, busy_o}, 32'd0);
        end
        ex_stall_i = 1'b0;
        a_i = 32'd9; b_i = 32'd3;
        @(negedge clk_i);
        chk("b2b_idle", {30'd0, busy_o, done_o}, 32'd0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            lat++;
            if (done_o) break;
        end
        start_i = 1'b0;
        chk("b2b_lat", 32'(lat), 32'd33);
        chk("b2b_res", result_o, 32'd3);

        // Asynchronous reset in the middle of a divide
        @(negedge clk_i);
        op_i = 3'd4; a_i = 32'hFFFFFFF9; b_i = 32'd2; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy_o}, 32'd0);
        chk("ar_done", {31'd0, done_o}, 32'd0);
        chk("ar_res", result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_op(3'd5, 32'd9, 32'd3, 32'd3, 33, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
